// File: rtl/l2_block_adapter_pkg.sv
// Shared coherence types for the L2 block adapter: status codes, adapter states, word type, block geometry helpers.
package l2_block_adapter_pkg;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        ACCESS = 3'd3,
        ERROR  = 3'd4
    } adapter_state_t;

    typedef logic [31:0] word_t;

    // Byte-offset bits covered by one block (word offset plus byte-in-word).
    function automatic int blk_off_w(input int block_size);
        return $clog2(block_size) + 2;
    endfunction

    function automatic int beat_cnt_w(input int block_size);
        return (block_size > 1) ? $clog2(block_size) : 1;
    endfunction

endpackage

// File: rtl/l2_beat_counter.sv
// Beat index within a block transfer, with clear/increment and a last-beat flag.
// Latency: count updates on the clock after clr/inc; last is combinational from count.
// Backpressure: none; the caller only pulses inc on completed beats.
module l2_beat_counter #(
    parameter int BLOCK_SIZE = 2,
    parameter int CNT_W      = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(BLOCK_SIZE - 1);

    assign last = (count == LAST_VAL);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l2_block_adapter.sv
// Turns one L2 block request into BLOCK_SIZE word beats on a busy-handshaked memory port.
// Latency: zero-wait block takes BLOCK_SIZE+1 cycles after acceptance, ending in a 1-cycle L2_ACCESS/L2_ERROR.
// Backpressure: each beat holds its strobe, address and data until mem_busy is low.
module l2_block_adapter
    import l2_block_adapter_pkg::*;
#(
    parameter int BLOCK_SIZE = 2,
    parameter int ADDR_W     = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    l2REN,
    input  logic                    l2WEN,
    input  logic [ADDR_W-1:0]       l2addr,
    input  logic [32*BLOCK_SIZE-1:0] l2store,
    output logic [32*BLOCK_SIZE-1:0] l2load,
    output l2_state_t               l2state,
    output logic                    mem_ren,
    output logic                    mem_wen,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_busy,
    input  logic                    mem_error
);

    localparam int OFF_W = blk_off_w(BLOCK_SIZE);
    localparam int CNT_W = beat_cnt_w(BLOCK_SIZE);
    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    adapter_state_t    state, next_state;
    logic [ADDR_W-1:0] base_addr;
    word_t             wr_words [BLOCK_SIZE];
    word_t             rd_words [BLOCK_SIZE];
    logic [CNT_W-1:0]  count;
    logic              cnt_last, cnt_clr, cnt_inc, cap_rd;

    l2_beat_counter #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .CNT_W      (CNT_W)
    ) u_beat_counter (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count),
        .last  (cnt_last)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        l2state    = L2_FREE;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        cap_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (l2WEN) begin
                    next_state = WRITE;
                end else if (l2REN) begin
                    next_state = READ;
                end
            end
            READ, WRITE: begin
                l2state = L2_BUSY;
                mem_ren = (state == READ);
                mem_wen = (state == WRITE);
                if (!mem_busy) begin
                    // An erroring beat's read data is not trusted, so it is never captured.
                    if (mem_error) begin
                        next_state = ERROR;
                        cnt_clr    = 1'b1;
                    end else begin
                        cap_rd = (state == READ);
                        if (cnt_last) begin
                            next_state = ACCESS;
                            cnt_clr    = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                l2state    = L2_ACCESS;
                next_state = IDLE;
            end
            ERROR: begin
                l2state    = L2_ERROR;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            base_addr <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                wr_words[i] <= '0;
                rd_words[i] <= '0;
            end
        end else begin
            if (state == IDLE && (l2WEN || l2REN)) begin
                base_addr <= l2addr & BASE_MASK;
                if (l2WEN) begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        wr_words[i] <= l2store[32*i +: 32];
                    end
                end
            end
            if (cap_rd) begin
                rd_words[count] <= mem_rdata;
            end
        end
    end

    assign mem_addr  = base_addr + ADDR_W'({count, 2'b00});
    assign mem_wdata = wr_words[count];

    always_comb begin
        l2load = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            l2load[32*i +: 32] = rd_words[i];
        end
    end

endmodule

// File: doc/l2_block_adapter.md
Name: l2_block_adapter

Overview:
- Sits directly downstream of the MESI bus controller; services its single L2 request port (l2REN/l2WEN, l2addr, l2store) and returns l2load plus an l2state status.
- Converts one cache-block request into BLOCK_SIZE sequential 32-bit beats on a simple word-wide memory port with a busy handshake.
- Reports completion with a one-cycle L2_ACCESS pulse, which the bus controller uses to drop dwait.

Parameters:
BLOCK_SIZE, 2, words per cache block; power of two, 1..8.
ADDR_W, 32, byte address width.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
l2REN  in  1  block read request from bus controller
l2WEN  in  1  block write request from bus controller
l2addr  in  ADDR_W  byte address, any offset within the block
l2store  in  32*BLOCK_SIZE  write block; word i at bits [32i+31:32i]
l2load  out  32*BLOCK_SIZE  read block, same packing
l2state  out  l2_state_t (2)  L2_FREE / L2_BUSY / L2_ACCESS / L2_ERROR
mem_ren  out  1  word read strobe
mem_wen  out  1  word write strobe
mem_addr  out  ADDR_W  word byte address
mem_wdata  out  32  write word
mem_rdata  in  32  read word, valid when mem_busy=0 during mem_ren
mem_busy  in  1  memory stall; beat completes on the cycle mem_busy=0 with strobe high
mem_error  in  1  beat error, qualified by mem_busy=0

Behaviour:
- Reset: state IDLE, beat counter 0, l2load 0, latched address/data 0, l2state L2_FREE, mem_ren/mem_wen 0, mem_addr 0, mem_wdata 0.
- FSM states: IDLE, READ, WRITE, ACCESS, ERROR.
- IDLE: l2state=L2_FREE.
  - l2WEN=1: latch the base address (l2addr with low log2(BLOCK_SIZE)+2 bits cleared) and l2store, go to WRITE.
  - else l2REN=1: latch the base address, go to READ.
  - If both are asserted, write wins.
- READ/WRITE: l2state=L2_BUSY; strobe held high.
  - mem_addr = base + 4*count; mem_wdata = latched word[count].
  - Beat completes when mem_busy=0.
  - On a completing read beat, capture mem_rdata into l2load word[count].
  - Completing beat with count=BLOCK_SIZE-1: go to ACCESS and clear the counter; otherwise count+1.
  - Counter width is max(1, log2(BLOCK_SIZE)); no wrap beyond the last word.
- ACCESS: exactly one cycle, l2state=L2_ACCESS, strobes low, l2load stable; then IDLE.
  - A request still asserted in ACCESS is not restarted in that cycle.
  - It is sampled again in IDLE on the next cycle.
- ERROR: mem_error=1 on any completing beat aborts the remaining beats and goes to ERROR.
  - ERROR is one cycle with l2state=L2_ERROR; then IDLE.
  - l2load words already captured are kept; the rest are unchanged.
- Request deassertion mid-transfer is ignored: the transaction always runs to ACCESS or ERROR, with no abort path.
- l2addr and l2store changes after acceptance have no effect, because the values are latched.
- Zero-wait latency for N=BLOCK_SIZE:
  - request seen in cycle 0 (IDLE);
  - beats in cycles 1..N;
  - L2_ACCESS in cycle N+1;
  - IDLE in cycle N+2.
  - Each stall cycle adds 1.
- l2load holds its value until the next read overwrites it; writes never modify l2load.
- Asynchronous reset mid-transaction returns to the reset values immediately; the memory strobe drops in the same instant.

Decomposition:
- Shared coherence package:
  - l2_state_t enum (L2_FREE=0, L2_BUSY=1, L2_ACCESS=2, L2_ERROR=3);
  - adapter state enum;
  - word_t (32-bit);
  - block-offset width constant derived from BLOCK_SIZE.
- One natural sub-module: l2_beat_counter (counter with load/increment/last flag), instantiated once.

Test Plan:
- Read, zero-wait, BLOCK_SIZE=2, l2addr=0x1004, memory returns 0xAAAA0000 at 0x1000 and 0xBBBB0001 at 0x1004 -> mem_addr 0x1000 then 0x1004; L2_ACCESS in cycle 3; l2load={0xBBBB0001,0xAAAA0000}.
- Write, mem_busy high 2 cycles on each beat, l2addr=0x2000, l2store={0x22222222,0x11111111} -> mem_wdata 0x11111111 @0x2000, then 0x22222222 @0x2004; L2_ACCESS in cycle 7; l2load unchanged.
- Simultaneous l2REN=1 and l2WEN=1 at 0x3000 -> only mem_wen strobes; no mem_ren is ever asserted.
- mem_error on beat 0 of a read at 0x4000 -> no beat at 0x4004; one cycle of L2_ERROR, then L2_FREE.
- l2REN held high through ACCESS -> state goes ACCESS, then IDLE for one cycle, then a new READ with L2_BUSY; there is no back-to-back beat without the IDLE cycle.
- nRST asserted during beat 1 of a write -> mem_wen drops immediately; after release, l2state=L2_FREE, counter 0, and the next read starts at beat 0.
